exc_ctrl_unit: RTL and testbench
================================

// Module: exc_ctrl_unit
// PURPOSE
// - Parametrised exception controller. It arbitrates exception requests from NUM_SRC pipeline stages plus one interrupt.
// - It latches EPC, cause and bad-address state, flushes the pipeline, and redirects fetch through a valid/ready handshake.
// - It handles ERET return. It sits between the pipeline stage registers and the CP0 register file.
// PARAMETERS
// NUM_SRC     4             number of exception sources; index NUM_SRC-1 is the oldest stage and has highest priority
// CODE_W      5             exception code width
// ADDR_W      32            PC / address width
// EXC_VECTOR  32'hBFC00380  redirect target for every exception and interrupt
// CNT_W       16            width of the saturating exception counter
// PORTS
// clk            in   1               clock, rising edge
// rst_n          in   1               asynchronous, active-low reset
// exc_valid      in   NUM_SRC         per-source exception request
// exc_code       in   NUM_SRC*CODE_W  per-source code; source i occupies bits [i*CODE_W +: CODE_W]
// exc_pc         in   NUM_SRC*ADDR_W  per-source faulting PC
// exc_badaddr    in   NUM_SRC*ADDR_W  per-source bad address; sampled only for ADDR_ERR_F / ADDR_ERR_M
// exc_bd         in   NUM_SRC         per-source "in delay slot" flag
// int_req        in   1               interrupt request, level-sensitive
// int_pc         in   ADDR_W          PC of the instruction the interrupt attaches to
// ie             in   1               global interrupt enable
// eret           in   1               ERET retiring
// redir_ready    in   1               fetch accepts redirect
// flush          out  1               pipeline flush pulse
// redir_valid    out  1               redirect offered to fetch
// redir_pc       out  ADDR_W          redirect target
// exl            out  1               exception level bit
// epc            out  ADDR_W          latched exception PC
// cause_code     out  CODE_W          latched exception code
// cause_bd       out  1               latched delay-slot flag
// badvaddr       out  ADDR_W          latched bad virtual address
// exc_onehot     out  2**CODE_W       one-hot decode of cause_code; valid while exl=1
// exc_cnt        out  CNT_W           saturating count of accepted exceptions and interrupts
// BEHAVIOUR
// - Reset: all outputs 0, FSM in IDLE. No registered state survives reset, including mid-flush or mid-redirect.
// - FSM has three states: IDLE, FLUSH, REDIR.
// - Winner selection, evaluated in IDLE only:
//   - highest index i with exc_valid[i]=1 wins;
//   - otherwise the interrupt wins when int_req & ie & ~exl; its code is INT (0).
// - IDLE -> FLUSH when there is a winner. At that clock edge:
//   - cause_code <= winner code;
//   - badvaddr <= winner exc_badaddr only if the code is ADDR_ERR_F or ADDR_ERR_M; otherwise badvaddr holds;
//   - if exl=0: epc <= winner PC (for a delay-slot winner, winner PC - 4), cause_bd <= winner bd, exl <= 1;
//   - if exl=1 (nested exception): epc and cause_bd hold;
//   - exc_cnt increments, saturating at all-ones.
// - IDLE -> REDIR on eret with no winner. At that clock edge: redir_pc <= epc, exl <= 0. No flush is issued.
// - eret and a winner in the same cycle: the exception wins and eret is dropped.
// - FLUSH lasts exactly 1 cycle with flush=1. Then -> REDIR with redir_pc = EXC_VECTOR.
// - REDIR: redir_valid=1. Return to IDLE in the cycle after redir_valid & redir_ready.
//   - redir_pc is stable while redir_valid=1 and ready=0.
// - Requests arriving in FLUSH or REDIR are ignored and not queued. Stages re-raise them after restart.
// - Latency from exception request to redir_valid: 2 cycles (request cycle, then FLUSH). From eret to redir_valid: 1 cycle.
// - exc_onehot: bit cause_code set when exl=1; all zeros when exl=0. Driven combinationally from registered state.
// - All arithmetic is unsigned. PC-4 wraps modulo 2**ADDR_W.
// STRUCTURE
// - head.v supplies the exception-code defines (INT, ADDR_ERR_F..BUS_ERR_M), ENABLE/DISABLE, and the FSM state encodings.
// - One sub-module, exc_prio_sel: combinational priority select over NUM_SRC sources.
//   - outputs: hit, sel_code, sel_pc, sel_badaddr, sel_bd.
// - FSM, CP0 state registers and onehot decode stay in the top module.
// TESTING
// - exc_valid=4'b0001, code=SYSCALL, pc=0x100, exl=0
//   -> flush=1 in cycle+1; redir_valid in cycle+2 with redir_pc=BFC00380; epc=0x100; exl=1; exc_cnt=1.
// - exc_valid=4'b1010, src3=ADDR_ERR_M with badaddr=0x2003, src1=OVERFLOW
//   -> cause_code=ADDR_ERR_M; badvaddr=0x2003; epc=src3 pc.
// - exc_bd[2]=1, pc=0x208 -> epc=0x204, cause_bd=1.
//   Then a second exception while exl=1 -> epc stays 0x204, cause_code updates.
// - eret with epc=0x400 and redir_ready held 0 for 3 cycles
//   -> redir_valid holds redir_pc=0x400 for 4 cycles; exl=0; no flush.
// - int_req=1, ie=1, exl=0, no exc_valid -> cause_code=0, epc=int_pc.
//   The same stimulus with ie=0 -> no action.
// - Assert rst_n=0 during REDIR -> all outputs 0 immediately; FSM in IDLE after release.
// - 2**CNT_W+1 accepted exceptions -> exc_cnt saturates at all-ones.

Source files
------------

// File: rtl/exc_ctrl_unit_pkg.sv
// Shared types and constants for the exception controller: FSM encoding,
// exception cause codes and the address-error classifier.
package exc_ctrl_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_REDIR = 2'd2
  } exc_state_e;

  localparam logic [4:0] EXC_INT        = 5'd0;
  localparam logic [4:0] EXC_ADDR_ERR_F = 5'd4;
  localparam logic [4:0] EXC_ADDR_ERR_M = 5'd5;
  localparam logic [4:0] EXC_BUS_ERR_F  = 5'd6;
  localparam logic [4:0] EXC_BUS_ERR_M  = 5'd7;
  localparam logic [4:0] EXC_SYSCALL    = 5'd8;
  localparam logic [4:0] EXC_BREAK      = 5'd9;
  localparam logic [4:0] EXC_OVERFLOW   = 5'd12;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  function automatic logic is_addr_err(input logic [4:0] code);
    return (code == EXC_ADDR_ERR_F) || (code == EXC_ADDR_ERR_M);
  endfunction

endpackage

// File: rtl/exc_ctrl_unit_prio_sel.sv
// Combinational priority select over the pipeline exception sources;
// the highest index (oldest stage) with a pending request wins.
module exc_prio_sel #(
  parameter int NUM_SRC = 4,
  parameter int CODE_W  = 5,
  parameter int ADDR_W  = 32
) (
  input  logic [NUM_SRC-1:0]        exc_valid,
  input  logic [NUM_SRC*CODE_W-1:0] exc_code,
  input  logic [NUM_SRC*ADDR_W-1:0] exc_pc,
  input  logic [NUM_SRC*ADDR_W-1:0] exc_badaddr,
  input  logic [NUM_SRC-1:0]        exc_bd,
  output logic                      hit,
  output logic [CODE_W-1:0]         sel_code,
  output logic [ADDR_W-1:0]         sel_pc,
  output logic [ADDR_W-1:0]         sel_badaddr,
  output logic                      sel_bd
);

  // Ascending scan: later (higher) indices overwrite earlier matches.
  always_comb begin
    hit         = 1'b0;
    sel_code    = '0;
    sel_pc      = '0;
    sel_badaddr = '0;
    sel_bd      = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (exc_valid[i]) begin
        hit         = 1'b1;
        sel_code    = exc_code[i*CODE_W +: CODE_W];
        sel_pc      = exc_pc[i*ADDR_W +: ADDR_W];
        sel_badaddr = exc_badaddr[i*ADDR_W +: ADDR_W];
        sel_bd      = exc_bd[i];
      end
    end
  end

endmodule

// File: rtl/exc_ctrl_unit.sv
// Exception controller: picks a winning exception/interrupt, latches CP0
// state (EPC, cause, badvaddr, EXL), flushes the pipe and redirects fetch.
module exc_ctrl_unit
  import exc_ctrl_unit_pkg::*;
#(
  parameter int                NUM_SRC    = 4,
  parameter int                CODE_W     = 5,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'hBFC00380,
  parameter int                CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        exc_valid,
  input  logic [NUM_SRC*CODE_W-1:0] exc_code,
  input  logic [NUM_SRC*ADDR_W-1:0] exc_pc,
  input  logic [NUM_SRC*ADDR_W-1:0] exc_badaddr,
  input  logic [NUM_SRC-1:0]        exc_bd,
  input  logic                      int_req,
  input  logic [ADDR_W-1:0]         int_pc,
  input  logic                      ie,
  input  logic                      eret,
  input  logic                      redir_ready,
  output logic                      flush,
  output logic                      redir_valid,
  output logic [ADDR_W-1:0]         redir_pc,
  output logic                      exl,
  output logic [ADDR_W-1:0]         epc,
  output logic [CODE_W-1:0]         cause_code,
  output logic                      cause_bd,
  output logic [ADDR_W-1:0]         badvaddr,
  output logic [2**CODE_W-1:0]      exc_onehot,
  output logic [CNT_W-1:0]          exc_cnt
);

  exc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] redir_pc_q, redir_pc_d;
  logic              exl_q, exl_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [CODE_W-1:0] cause_code_q, cause_code_d;
  logic              cause_bd_q, cause_bd_d;
  logic [ADDR_W-1:0] badvaddr_q, badvaddr_d;
  logic [CNT_W-1:0]  exc_cnt_q, exc_cnt_d;

  logic              src_hit;
  logic [CODE_W-1:0] src_code;
  logic [ADDR_W-1:0] src_pc;
  logic [ADDR_W-1:0] src_badaddr;
  logic              src_bd;

  exc_prio_sel #(
    .NUM_SRC (NUM_SRC),
    .CODE_W  (CODE_W),
    .ADDR_W  (ADDR_W)
  ) u_prio_sel (
    .exc_valid   (exc_valid),
    .exc_code    (exc_code),
    .exc_pc      (exc_pc),
    .exc_badaddr (exc_badaddr),
    .exc_bd      (exc_bd),
    .hit         (src_hit),
    .sel_code    (src_code),
    .sel_pc      (src_pc),
    .sel_badaddr (src_badaddr),
    .sel_bd      (src_bd)
  );

  logic              int_win;
  logic              win;
  logic [CODE_W-1:0] win_code;
  logic [ADDR_W-1:0] win_pc;
  logic              win_bd;

  // Interrupts are masked while already at exception level.
  assign int_win  = int_req & ie & ~exl_q;
  assign win      = src_hit | int_win;
  assign win_code = src_hit ? src_code : CODE_W'(EXC_INT);
  assign win_pc   = src_hit ? src_pc : int_pc;
  assign win_bd   = src_hit & src_bd;

  always_comb begin
    state_d      = state_q;
    redir_pc_d   = redir_pc_q;
    exl_d        = exl_q;
    epc_d        = epc_q;
    cause_code_d = cause_code_q;
    cause_bd_d   = cause_bd_q;
    badvaddr_d   = badvaddr_q;
    exc_cnt_d    = exc_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win) begin
          state_d      = ST_FLUSH;
          cause_code_d = win_code;
          if (is_addr_err(5'(win_code))) badvaddr_d = src_badaddr;
          // Nested exceptions keep the original return point.
          if (!exl_q) begin
            epc_d      = win_bd ? (win_pc - ADDR_W'(4)) : win_pc;
            cause_bd_d = win_bd;
            exl_d      = ENABLE;
          end
          if (exc_cnt_q != '1) exc_cnt_d = exc_cnt_q + CNT_W'(1);
        end else if (eret) begin
          state_d    = ST_REDIR;
          redir_pc_d = epc_q;
          exl_d      = DISABLE;
        end
      end
      ST_FLUSH: begin
        state_d    = ST_REDIR;
        redir_pc_d = EXC_VECTOR;
      end
      ST_REDIR: begin
        if (redir_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      redir_pc_q   <= '0;
      exl_q        <= 1'b0;
      epc_q        <= '0;
      cause_code_q <= '0;
      cause_bd_q   <= 1'b0;
      badvaddr_q   <= '0;
      exc_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      redir_pc_q   <= redir_pc_d;
      exl_q        <= exl_d;
      epc_q        <= epc_d;
      cause_code_q <= cause_code_d;
      cause_bd_q   <= cause_bd_d;
      badvaddr_q   <= badvaddr_d;
      exc_cnt_q    <= exc_cnt_d;
    end
  end

  always_comb begin
    exc_onehot = '0;
    if (exl_q) exc_onehot[cause_code_q] = 1'b1;
  end

  assign flush       = (state_q == ST_FLUSH);
  assign redir_valid = (state_q == ST_REDIR);
  assign redir_pc    = redir_pc_q;
  assign exl         = exl_q;
  assign epc         = epc_q;
  assign cause_code  = cause_code_q;
  assign cause_bd    = cause_bd_q;
  assign badvaddr    = badvaddr_q;
  assign exc_cnt     = exc_cnt_q;

endmodule

// File: tb/tb_exc_ctrl_unit.sv
// Scoreboard bench for exc_ctrl_unit: stimulus pushes expected redirect
// records, a negedge monitor checks them at each accepted redirect.
module tb_exc_ctrl_unit;
  import exc_ctrl_unit_pkg::*;

  localparam int NS   = 4;
  localparam int CW   = 5;
  localparam int AW   = 32;
  localparam int CNTW = 4;
  localparam logic [31:0] VEC = 32'hBFC00380;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NS-1:0]   exc_valid = '0;
  logic [NS*CW-1:0] exc_code = '0;
  logic [NS*AW-1:0] exc_pc = '0;
  logic [NS*AW-1:0] exc_badaddr = '0;
  logic [NS-1:0]   exc_bd = '0;
  logic            int_req = 1'b0;
  logic [AW-1:0]   int_pc = '0;
  logic            ie = 1'b0;
  logic            eret = 1'b0;
  logic            redir_ready = 1'b1;
  logic            flush, redir_valid, exl, cause_bd;
  logic [AW-1:0]   redir_pc, epc, badvaddr;
  logic [CW-1:0]   cause_code;
  logic [2**CW-1:0] exc_onehot;
  logic [CNTW-1:0] exc_cnt;

  exc_ctrl_unit #(.NUM_SRC(NS), .CODE_W(CW), .ADDR_W(AW), .EXC_VECTOR(VEC), .CNT_W(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_badaddr(exc_badaddr), .exc_bd(exc_bd), .int_req(int_req), .int_pc(int_pc), .ie(ie),
    .eret(eret), .redir_ready(redir_ready), .flush(flush), .redir_valid(redir_valid),
    .redir_pc(redir_pc), .exl(exl), .epc(epc), .cause_code(cause_code), .cause_bd(cause_bd),
    .badvaddr(badvaddr), .exc_onehot(exc_onehot), .exc_cnt(exc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        exl;
    logic [31:0] epc;
    logic [4:0]  code;
    logic        bd;
    logic [31:0] badv;
    logic [3:0]  cnt;
    logic        fl;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  logic flush_seen = 1'b0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (flush) flush_seen = 1'b1;
      if (redir_valid) begin
        if (q.size() == 0) begin
          chk("spurious_redir", 64'(redir_valid), 64'd0);
        end else begin
          exp_t e;
          e = q[0];
          chk("redir_pc", 64'(redir_pc), 64'(e.pc));
          if (redir_ready) begin
            void'(q.pop_front());
            chk("exl", 64'(exl), 64'(e.exl));
            chk("epc", 64'(epc), 64'(e.epc));
            chk("cause_code", 64'(cause_code), 64'(e.code));
            chk("cause_bd", 64'(cause_bd), 64'(e.bd));
            chk("badvaddr", 64'(badvaddr), 64'(e.badv));
            chk("exc_cnt", 64'(exc_cnt), 64'(e.cnt));
            chk("exc_onehot", 64'(exc_onehot), e.exl ? (64'd1 << e.code) : 64'd0);
            chk("flush_seen", 64'(flush_seen), 64'(e.fl));
            flush_seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic x, input logic [31:0] ep,
                          input logic [4:0] code, input logic bd, input logic [31:0] bv,
                          input logic [3:0] cnt, input logic fl);
    exp_t e;
    e.pc = pc; e.exl = x; e.epc = ep; e.code = code; e.bd = bd; e.badv = bv; e.cnt = cnt; e.fl = fl;
    q.push_back(e);
  endtask

  task automatic set_src(input int i, input logic [4:0] code, input logic [31:0] pc,
                         input logic [31:0] bad, input logic bd);
    exc_code[i*CW +: CW]    = code;
    exc_pc[i*AW +: AW]      = pc;
    exc_badaddr[i*AW +: AW] = bad;
    exc_bd[i]               = bd;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((flush || redir_valid) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("wait_idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic run_exc(input logic [NS-1:0] mask);
    exc_valid = mask;
    tick();
    exc_valid = '0;
    wait_idle();
  endtask

  task automatic run_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    wait_idle();
  endtask

  initial begin
    int cyc;
    #12;
    chk("rst_redir_valid", 64'(redir_valid), 64'd0);
    chk("rst_epc_exl_cnt", {epc, 27'd0, exl, exc_cnt}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Single SYSCALL from source 0, with explicit latency checks.
    set_src(0, EXC_SYSCALL, 32'h100, 32'h0, 1'b0);
    push_exp(VEC, 1'b1, 32'h100, EXC_SYSCALL, 1'b0, 32'h0, 4'd1, 1'b1);
    exc_valid = 4'b0001;
    chk("t1_no_flush_yet", 64'(flush), 64'd0);
    tick();
    exc_valid = '0;
    chk("t1_flush_c1", 64'(flush), 64'd1);
    tick();
    chk("t1_redir_c2", 64'(redir_valid), 64'd1);
    chk("t1_redir_pc_c2", 64'(redir_pc), 64'(VEC));
    wait_idle();
    push_exp(32'h100, 1'b0, 32'h100, EXC_SYSCALL, 1'b0, 32'h0, 4'd1, 1'b0);
    run_eret();

    // Two sources: src3 (ADDR_ERR_M) outranks src1 (OVERFLOW).
    set_src(3, EXC_ADDR_ERR_M, 32'h300, 32'h2003, 1'b0);
    set_src(1, EXC_OVERFLOW, 32'h110, 32'hDEAD, 1'b0);
    push_exp(VEC, 1'b1, 32'h300, EXC_ADDR_ERR_M, 1'b0, 32'h2003, 4'd2, 1'b1);
    run_exc(4'b1010);
    push_exp(32'h300, 1'b0, 32'h300, EXC_ADDR_ERR_M, 1'b0, 32'h2003, 4'd2, 1'b0);
    run_eret();

    // Delay-slot winner, then a nested exception that must keep epc/bd.
    set_src(2, EXC_BREAK, 32'h208, 32'h5555, 1'b1);
    push_exp(VEC, 1'b1, 32'h204, EXC_BREAK, 1'b1, 32'h2003, 4'd3, 1'b1);
    run_exc(4'b0100);
    set_src(0, EXC_ADDR_ERR_F, 32'h500, 32'h7777, 1'b0);
    push_exp(VEC, 1'b1, 32'h204, EXC_ADDR_ERR_F, 1'b1, 32'h7777, 4'd4, 1'b1);
    run_exc(4'b0001);
    push_exp(32'h204, 1'b0, 32'h204, EXC_ADDR_ERR_F, 1'b1, 32'h7777, 4'd4, 1'b0);
    run_eret();

    // ERET to 0x400 with fetch stalled for three cycles.
    set_src(0, EXC_SYSCALL, 32'h400, 32'h0, 1'b0);
    push_exp(VEC, 1'b1, 32'h400, EXC_SYSCALL, 1'b0, 32'h7777, 4'd5, 1'b1);
    run_exc(4'b0001);
    push_exp(32'h400, 1'b0, 32'h400, EXC_SYSCALL, 1'b0, 32'h7777, 4'd5, 1'b0);
    redir_ready = 1'b0;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    cyc = 0;
    for (int k = 0; k < 3; k++) begin
      if (redir_valid) cyc++;
      tick();
    end
    redir_ready = 1'b1;
    if (redir_valid) cyc++;
    chk("eret_stall_pc", 64'(redir_pc), 64'h400);
    tick();
    chk("eret_valid_cycles", 64'(cyc), 64'd4);
    chk("eret_released", 64'(redir_valid), 64'd0);

    // Interrupt with ie=1, then with ie=0 (must be ignored).
    int_pc = 32'h600;
    ie = 1'b1;
    push_exp(VEC, 1'b1, 32'h600, EXC_INT, 1'b0, 32'h7777, 4'd6, 1'b1);
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    wait_idle();
    push_exp(32'h600, 1'b0, 32'h600, EXC_INT, 1'b0, 32'h7777, 4'd6, 1'b0);
    run_eret();
    ie = 1'b0;
    int_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ie0_no_action", {62'd0, flush, redir_valid}, 64'd0);
    end
    int_req = 1'b0;
    chk("ie0_cnt_held", 64'(exc_cnt), 64'd6);

    // Exception and ERET together: exception wins.
    set_src(1, EXC_OVERFLOW, 32'h700, 32'h0, 1'b0);
    push_exp(VEC, 1'b1, 32'h700, EXC_OVERFLOW, 1'b0, 32'h7777, 4'd7, 1'b1);
    eret = 1'b1;
    exc_valid = 4'b0010;
    tick();
    eret = 1'b0;
    exc_valid = '0;
    wait_idle();

    // Reset asserted while a redirect is stalled in REDIR.
    redir_ready = 1'b0;
    set_src(0, EXC_SYSCALL, 32'h800, 32'h0, 1'b0);
    push_exp(VEC, 1'b1, 32'h700, EXC_SYSCALL, 1'b0, 32'h7777, 4'd8, 1'b1);
    exc_valid = 4'b0001;
    tick();
    exc_valid = '0;
    tick();
    chk("pre_rst_redir", 64'(redir_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_ctl", {61'd0, flush, redir_valid, exl}, 64'd0);
    chk("rst_async_pc", {redir_pc, epc}, 64'd0);
    chk("rst_async_cause", {badvaddr, exc_onehot}, 64'd0);
    chk("rst_async_misc", {54'd0, cause_code, cause_bd, exc_cnt}, 64'd0);
    q.delete();
    flush_seen = 1'b0;
    redir_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {61'd0, flush, redir_valid, exl}, 64'd0);

    // Counter saturation: 2**CNT_W+1 nested exceptions.
    for (int k = 0; k < 17; k++) begin
      set_src(0, EXC_SYSCALL, 32'h900 + 32'(k * 4), 32'h0, 1'b0);
      push_exp(VEC, 1'b1, 32'h900, EXC_SYSCALL, 1'b0, 32'h0, (k >= 15) ? 4'hF : 4'(k + 1), 1'b1);
      run_exc(4'b0001);
    end
    chk("cnt_saturated", 64'(exc_cnt), 64'hF);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
